fetch_ctrl: RTL

Sequencing controller for the fetch stage: owns the `stallF`/`npc` inputs of the PC register and the write port of instruction memory. After reset it accepts a boot program stream into instruction memory, then releases fetch at the reset vector. While running it arbitrates between next-PC sources: halt, branch/jump redirect, hazard stall and sequential increment. Sits between the decode/hazard logic and `fetch`.

---
 rtl/fetch_ctrl_pkg.sv | 31 +++
 rtl/fetch_ctrl_if.sv | 36 +++
 rtl/fetch_ctrl_npc_select.sv | 54 +++++
 rtl/fetch_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_ctrl_pkg
//  Purpose  : Shared types and constants for the fetch-stage sequencing
//             controller: word width, PC increment, FSM state encodings and
//             next-PC source identifiers.
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

   localparam int          WORD_WIDTH = 32;
   localparam logic [31:0] PC_INC     = 32'd4;

   // Controller state; encodings are fixed so they can be matched in traces.
   typedef enum logic [1:0] {
      FC_LOAD  = 2'd0,
      FC_START = 2'd1,
      FC_RUN   = 2'd2,
      FC_HALT  = 2'd3
   } fc_state_t;

   // Which next-PC source won arbitration in the current RUN cycle.
   typedef enum logic [1:0] {
      SRC_HALT     = 2'd0,
      SRC_REDIRECT = 2'd1,
      SRC_STALL    = 2'd2,
      SRC_SEQ      = 2'd3
   } npc_src_t;

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_ctrl_if
//  Purpose  : Boot-load stream and instruction-memory write port of the
//             fetch controller.
//  Ports    : load_valid/load_data/load_last -> boot word stream
//             load_ready                     <- controller accepts a word
//             imem_we/imem_waddr/imem_wdata  <- instruction-memory write
//  Modports : master = boot source / memory side, slave = controller
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if #(
   parameter int IMEM_DEPTH = 1024
) ();
   localparam int AW = $clog2(IMEM_DEPTH);

   logic          load_valid;
   logic [31:0]   load_data;
   logic          load_last;
   logic          load_ready;
   logic          imem_we;
   logic [AW-1:0] imem_waddr;
   logic [31:0]   imem_wdata;

   modport master (
      output load_valid, load_data, load_last,
      input  load_ready, imem_we, imem_waddr, imem_wdata
   );

   modport slave (
      input  load_valid, load_data, load_last,
      output load_ready, imem_we, imem_waddr, imem_wdata
   );

endinterface
`default_nettype wire

// File: rtl/fetch_ctrl_npc_select.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_ctrl_npc_select
//  Purpose  : Combinational next-PC priority mux used while the controller
//             is running: halt > redirect > hazard stall > sequential.
//  Ports    : pcF, stall_hazard, redirect_valid, redirect_pc, halt_req (in)
//             npc, stallF, flushD, src (out; src names the winning source)
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl_npc_select
   import fetch_ctrl_pkg::*;
(
   input  logic [WORD_WIDTH-1:0] pcF,
   input  logic                  stall_hazard,
   input  logic                  redirect_valid,
   input  logic [WORD_WIDTH-1:0] redirect_pc,
   input  logic                  halt_req,
   output logic [WORD_WIDTH-1:0] npc,
   output logic                  stallF,
   output logic                  flushD,
   output npc_src_t              src
);

   logic [WORD_WIDTH-1:0] pc_seq;
   logic                  unused_align;

   // 32-bit modulo add: the top word address wraps to 0.
   assign pc_seq       = pcF + PC_INC;
   // Redirect targets are forced word-aligned, so the low bits are dropped.
   assign unused_align = &redirect_pc[1:0];

   always_comb begin
      src    = SRC_SEQ;
      npc    = pc_seq;
      stallF = 1'b0;
      flushD = 1'b0;
      if (halt_req) begin
         src    = SRC_HALT;
         stallF = 1'b1;
         flushD = 1'b1;
      end else if (redirect_valid) begin
         // Redirect beats a simultaneous hazard stall: the stalled
         // instruction is on the wrong path and is flushed anyway.
         src    = SRC_REDIRECT;
         npc    = {redirect_pc[WORD_WIDTH-1:2], 2'b00};
         flushD = 1'b1;
      end else if (stall_hazard) begin
         src    = SRC_STALL;
         stallF = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_ctrl
//  Purpose  : Fetch-stage sequencing controller. Loads a boot program into
//             instruction memory after reset, releases fetch at RESET_PC,
//             then arbitrates next-PC sources until halted.
//  Ports    : clk, rst (async, active-low)
//             boot  : fetch_ctrl_if.slave (boot stream + imem write port)
//             pcF, stall_hazard, redirect_valid, redirect_pc, halt_req (in)
//             stallF, npc, flushD, running (out)
//             stall_cycles, redirect_count (out, performance counters)
//  Config   : FETCH_CTRL_PERF_EN - build saturating performance counters;
//             when undefined the counter ports are tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_DEPTH = 1024,
   parameter int          CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   fetch_ctrl_if.slave           boot,
   input  logic [WORD_WIDTH-1:0] pcF,
   input  logic                  stall_hazard,
   input  logic                  redirect_valid,
   input  logic [WORD_WIDTH-1:0] redirect_pc,
   input  logic                  halt_req,
   output logic                  stallF,
   output logic [WORD_WIDTH-1:0] npc,
   output logic                  flushD,
   output logic                  running,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      redirect_count
);

   localparam int          AW        = $clog2(IMEM_DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(IMEM_DEPTH - 1);

   fc_state_t             state;
   logic [AW-1:0]         wcnt;
   logic                  load_ready;
   logic                  beat;
   logic [WORD_WIDTH-1:0] sel_npc;
   logic                  sel_stallF;
   logic                  sel_flushD;
   npc_src_t              src;

   fetch_ctrl_npc_select u_npc_select (
      .pcF            (pcF),
      .stall_hazard   (stall_hazard),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .npc            (sel_npc),
      .stallF         (sel_stallF),
      .flushD         (sel_flushD),
      .src            (src)
   );

   assign load_ready = (state == FC_LOAD);
   assign beat       = boot.load_valid && load_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= FC_LOAD;
         wcnt  <= '0;
      end else begin
         case (state)
            FC_LOAD: begin
               if (beat) begin
                  wcnt <= wcnt + AW'(1);
                  // The beat at the last address ends the load even without
                  // load_last, so the counter never wraps onto word 0.
                  if (boot.load_last || (wcnt == LAST_ADDR)) begin
                     state <= FC_START;
                  end
               end
            end
            FC_START: state <= FC_RUN;
            FC_RUN: begin
               if (src == SRC_HALT) begin
                  state <= FC_HALT;
               end
            end
            FC_HALT: state <= FC_HALT;
            default: state <= FC_HALT;
         endcase
      end
   end

   // Write is issued in the handshake cycle itself.
   assign boot.load_ready = load_ready;
   assign boot.imem_we    = beat;
   assign boot.imem_waddr = wcnt;
   assign boot.imem_wdata = boot.load_data;

   always_comb begin
      stallF  = 1'b1;
      npc     = RESET_PC;
      flushD  = 1'b1;
      running = 1'b0;
      case (state)
         FC_START: stallF = 1'b0;   // PC takes RESET_PC on the next edge
         FC_RUN: begin
            running = 1'b1;
            stallF  = sel_stallF;
            npc     = sel_npc;
            flushD  = sel_flushD;
         end
         default: ;                 // LOAD and HALT keep fetch frozen
      endcase
   end

`ifdef FETCH_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] redir_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         redir_cnt <= '0;
      end else if (state == FC_RUN) begin
         if ((src == SRC_STALL) && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if ((src == SRC_REDIRECT) && (redir_cnt != {CNT_W{1'b1}})) begin
            redir_cnt <= redir_cnt + CNT_W'(1);
         end
      end
   end

   assign stall_cycles   = stall_cnt;
   assign redirect_count = redir_cnt;
`else
   assign stall_cycles   = '0;
   assign redirect_count = '0;
`endif

endmodule
`default_nettype wire
